// File: rtl/map_flow_lookup_pkg.sv
// Shared widths, key layout, table entry format and FSM encoding for the flow lookup block.
// No logic; types and constants only.
// Consumers import with map_flow_lookup_pkg::*.
package map_flow_lookup_pkg;

  // Datapath widths
  localparam int KEY_W    = 104;
  localparam int FLOWID_W = 14;
  localparam int BUFID_W  = 9;
  localparam int DMAC_W   = 48;
  localparam int DROP_W   = 16;

  // 5-tuple field placement inside the key
  localparam int PROTO_LSB = 96;
  localparam int SIP_LSB   = 64;
  localparam int DIP_LSB   = 32;
  localparam int SPORT_LSB = 16;
  localparam int DPORT_LSB = 0;
  localparam int PROTO_W   = 8;
  localparam int IP_W      = 32;
  localparam int PORT_W    = 16;

  typedef logic [KEY_W-1:0]    key_t;
  typedef logic [FLOWID_W-1:0] flowid_t;
  typedef logic [BUFID_W-1:0]  bufid_t;
  typedef logic [DMAC_W-1:0]   dmac_t;
  typedef logic [DROP_W-1:0]   drop_cnt_t;

  // One mapping table entry
  typedef struct packed {
    logic    valid;
    key_t    key;
    flowid_t flowid;
  } tbl_entry_t;

  // Lookup FSM encoding
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_OUTPUT = 2'd2
  } lookup_st_e;

  // Assemble a key from its 5-tuple fields
  function automatic key_t make_key(input logic [PROTO_W-1:0] proto,
                                    input logic [IP_W-1:0]    sip,
                                    input logic [IP_W-1:0]    dip,
                                    input logic [PORT_W-1:0]  sport,
                                    input logic [PORT_W-1:0]  dport);
    key_t k;
    k = '0;
    k[PROTO_LSB +: PROTO_W] = proto;
    k[SIP_LSB   +: IP_W]    = sip;
    k[DIP_LSB   +: IP_W]    = dip;
    k[SPORT_LSB +: PORT_W]  = sport;
    k[DPORT_LSB +: PORT_W]  = dport;
    return k;
  endfunction

endpackage

// File: rtl/map_flow_lookup_if.sv
// Bundles the key request, table config and lookup result signals of the flow lookup block.
// No latency; wiring only.
// No backpressure: key and config are strobes, result is a single-cycle strobe.
interface map_flow_lookup_if #(
  parameter int ENTRY_NUM = 8
);
  import map_flow_lookup_pkg::*;

  localparam int ADDR_W = $clog2(ENTRY_NUM);

  // Key request
  key_t               iv_5tuple_data;
  logic               i_5tuple_data_wr;
  dmac_t              iv_dmac;
  bufid_t             iv_bufid;
  logic               i_tcp_or_udp_flag;

  // Table configuration
  logic               i_cfg_wr;
  logic [ADDR_W-1:0]  iv_cfg_addr;
  key_t               iv_cfg_key;
  flowid_t            iv_cfg_flowid;
  logic               i_cfg_valid;

  // Lookup result
  flowid_t            ov_flowid;
  logic               o_hit;
  dmac_t              ov_dmac;
  bufid_t             ov_bufid;
  logic               o_lookup_wr;
  drop_cnt_t          ov_drop_cnt;

  // Requester / configurator side
  modport master (
    output iv_5tuple_data, i_5tuple_data_wr, iv_dmac, iv_bufid, i_tcp_or_udp_flag,
    output i_cfg_wr, iv_cfg_addr, iv_cfg_key, iv_cfg_flowid, i_cfg_valid,
    input  ov_flowid, o_hit, ov_dmac, ov_bufid, o_lookup_wr, ov_drop_cnt
  );

  // Lookup engine side
  modport slave (
    input  iv_5tuple_data, i_5tuple_data_wr, iv_dmac, iv_bufid, i_tcp_or_udp_flag,
    input  i_cfg_wr, iv_cfg_addr, iv_cfg_key, iv_cfg_flowid, i_cfg_valid,
    output ov_flowid, o_hit, ov_dmac, ov_bufid, o_lookup_wr, ov_drop_cnt
  );

endinterface

// File: rtl/map_flow_table.sv
// Register-based flow mapping table with one config write port and one indexed read port.
// Write lands on the edge after cfg_wr; read is combinational from the registered entries.
// No backpressure: writes accepted every cycle, including during a search.
module map_flow_table
  import map_flow_lookup_pkg::*;
#(
  parameter int ENTRY_NUM = 8,
  parameter int ADDR_W    = $clog2(ENTRY_NUM)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              cfg_wr,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  key_t              cfg_key,
  input  flowid_t           cfg_flowid,
  input  logic              cfg_valid,
  input  logic [ADDR_W-1:0] rd_idx,
  output tbl_entry_t        rd_entry
);

  tbl_entry_t entry_q [ENTRY_NUM];

  // Entry storage: reset wipes every entry, otherwise a config strobe overwrites one entry
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < ENTRY_NUM; i++) begin
        entry_q[i] <= '0;
      end
    end else if (cfg_wr) begin
      entry_q[cfg_addr] <= '{valid: cfg_valid, key: cfg_key, flowid: cfg_flowid};
    end
  end

  // A compare in the write cycle sees the pre-write contents
  assign rd_entry = entry_q[rd_idx];

endmodule

// File: rtl/map_flow_lookup.sv
// 5-tuple to TSN flow id lookup: sequential scan of the mapping table, lowest matching index wins.
// Result strobe ENTRY_NUM+1 cycles after the key strobe, fixed for hit, miss and non-TCP/UDP keys.
// One lookup in flight; keys arriving while busy are dropped and counted (saturating).
module map_flow_lookup
  import map_flow_lookup_pkg::*;
#(
  parameter int ENTRY_NUM = 8
) (
  input logic               i_clk,
  input logic               i_rst,
  map_flow_lookup_if.slave  bus
);

  localparam int ADDR_W = $clog2(ENTRY_NUM);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(ENTRY_NUM - 1);

  lookup_st_e        st_q, st_d;
  logic [ADDR_W-1:0] idx_q;
  key_t              key_dat_q;
  dmac_t             dmac_dat_q;
  bufid_t            bufid_dat_q;
  logic              flag_q;
  logic              hit_q;
  flowid_t           hit_flowid_q;

  tbl_entry_t        rd_entry;
  logic              last_idx;
  logic              cmp_match;
  logic              key_accept;
  logic              key_drop;
  logic              result_vld;
  logic              final_hit;
  flowid_t           final_flowid;

  flowid_t           flowid_q;
  logic              o_hit_q;
  dmac_t             dmac_out_q;
  bufid_t            bufid_out_q;
  logic              lookup_wr_q;
  drop_cnt_t         drop_cnt_q;

  map_flow_table #(
    .ENTRY_NUM (ENTRY_NUM),
    .ADDR_W    (ADDR_W)
  ) u_table (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .cfg_wr     (bus.i_cfg_wr),
    .cfg_addr   (bus.iv_cfg_addr),
    .cfg_key    (bus.iv_cfg_key),
    .cfg_flowid (bus.iv_cfg_flowid),
    .cfg_valid  (bus.i_cfg_valid),
    .rd_idx     (idx_q),
    .rd_entry   (rd_entry)
  );

  assign last_idx   = (idx_q == LAST_IDX);
  // Non-TCP/UDP keys never match, but the scan still runs its full length
  assign cmp_match  = (st_q == ST_SEARCH) && rd_entry.valid && flag_q &&
                      (rd_entry.key == key_dat_q);
  assign result_vld = (st_q == ST_SEARCH) && last_idx;

  // The final compare happens in the same cycle the result is registered
  assign final_hit    = hit_q | cmp_match;
  assign final_flowid = hit_q     ? hit_flowid_q    :
                        cmp_match ? rd_entry.flowid : '0;

  // FSM state register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      st_q <= ST_IDLE;
    end else begin
      st_q <= st_d;
    end
  end

  // FSM next state plus key accept/drop decode
  always_comb begin
    st_d       = st_q;
    key_accept = 1'b0;
    key_drop   = 1'b0;
    case (st_q)
      ST_IDLE: begin
        if (bus.i_5tuple_data_wr) begin
          key_accept = 1'b1;
          st_d       = ST_SEARCH;
        end
      end
      ST_SEARCH: begin
        key_drop = bus.i_5tuple_data_wr;
        if (last_idx) begin
          st_d = ST_OUTPUT;
        end
      end
      ST_OUTPUT: begin
        key_drop = bus.i_5tuple_data_wr;
        st_d     = ST_IDLE;
      end
      default: begin
        st_d = ST_IDLE;
      end
    endcase
  end

  // Request latches and scan index: loaded on accept, index advances every search cycle
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      idx_q       <= '0;
      key_dat_q   <= '0;
      dmac_dat_q  <= '0;
      bufid_dat_q <= '0;
      flag_q      <= 1'b0;
    end else if (key_accept) begin
      idx_q       <= '0;
      key_dat_q   <= bus.iv_5tuple_data;
      dmac_dat_q  <= bus.iv_dmac;
      bufid_dat_q <= bus.iv_bufid;
      flag_q      <= bus.i_tcp_or_udp_flag;
    end else if (st_q == ST_SEARCH) begin
      idx_q <= idx_q + ADDR_W'(1);
    end
  end

  // First-match capture: once set, later matching entries are ignored
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      hit_q        <= 1'b0;
      hit_flowid_q <= '0;
    end else if (key_accept) begin
      hit_q        <= 1'b0;
      hit_flowid_q <= '0;
    end else if (cmp_match && !hit_q) begin
      hit_q        <= 1'b1;
      hit_flowid_q <= rd_entry.flowid;
    end
  end

  // Result registers: strobe and hit for one cycle, data fields hold until the next result
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      lookup_wr_q <= 1'b0;
      o_hit_q     <= 1'b0;
      flowid_q    <= '0;
      dmac_out_q  <= '0;
      bufid_out_q <= '0;
    end else begin
      lookup_wr_q <= 1'b0;
      o_hit_q     <= 1'b0;
      if (result_vld) begin
        lookup_wr_q <= 1'b1;
        o_hit_q     <= final_hit;
        flowid_q    <= final_flowid;
        dmac_out_q  <= dmac_dat_q;
        bufid_out_q <= bufid_dat_q;
      end
    end
  end

  // Saturating count of keys discarded while a lookup is in flight
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      drop_cnt_q <= '0;
    end else if (key_drop && (drop_cnt_q != '1)) begin
      drop_cnt_q <= drop_cnt_q + DROP_W'(1);
    end
  end

  assign bus.o_lookup_wr = lookup_wr_q;
  assign bus.o_hit       = o_hit_q;
  assign bus.ov_flowid   = flowid_q;
  assign bus.ov_dmac     = dmac_out_q;
  assign bus.ov_bufid    = bufid_out_q;
  assign bus.ov_drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_map_flow_lookup.sv
// Scoreboard bench for map_flow_lookup: directed key/config sequences push expected results,
// a negedge monitor pops and compares each result strobe, including its arrival cycle.
// Direct checks cover reset state, held outputs and the drop counter.
module tb_map_flow_lookup;
  import map_flow_lookup_pkg::*;

  localparam int N = 8;

  typedef struct {
    logic    hit;
    flowid_t flowid;
    dmac_t   dmac;
    bufid_t  bufid;
    int      cyc;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   errors;
  int   checks;
  exp_t exp_q[$];

  map_flow_lookup_if #(.ENTRY_NUM(N)) dut_if ();

  map_flow_lookup #(.ENTRY_NUM(N)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (dut_if.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_key(input key_t k, input dmac_t d, input bufid_t b, input logic f,
                          output int t);
    dut_if.iv_5tuple_data    = k;
    dut_if.iv_dmac           = d;
    dut_if.iv_bufid          = b;
    dut_if.i_tcp_or_udp_flag = f;
    dut_if.i_5tuple_data_wr  = 1'b1;
    t = cyc;
    tick();
    dut_if.i_5tuple_data_wr  = 1'b0;
  endtask

  task automatic cfg_write(input int addr, input key_t k, input flowid_t fid, input logic v);
    dut_if.iv_cfg_addr   = addr[2:0];
    dut_if.iv_cfg_key    = k;
    dut_if.iv_cfg_flowid = fid;
    dut_if.i_cfg_valid   = v;
    dut_if.i_cfg_wr      = 1'b1;
    tick();
    dut_if.i_cfg_wr      = 1'b0;
  endtask

  task automatic push_exp(input logic h, input flowid_t fid, input dmac_t d, input bufid_t b,
                          input int c);
    exp_t e;
    e.hit = h; e.flowid = fid; e.dmac = d; e.bufid = b; e.cyc = c;
    exp_q.push_back(e);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_lookup_wr"}, 64'(dut_if.o_lookup_wr), 64'd0);
    chk({tag, "_hit"},       64'(dut_if.o_hit),       64'd0);
    chk({tag, "_flowid"},    64'(dut_if.ov_flowid),   64'd0);
    chk({tag, "_dmac"},      64'(dut_if.ov_dmac),     64'd0);
    chk({tag, "_bufid"},     64'(dut_if.ov_bufid),    64'd0);
    chk({tag, "_drop_cnt"},  64'(dut_if.ov_drop_cnt), 64'd0);
  endtask

  // Monitor: every result strobe must match the head of the scoreboard, on its cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (dut_if.o_lookup_wr === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 64'(dut_if.o_lookup_wr), 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("res_hit",     64'(dut_if.o_hit),     64'(e.hit));
          chk("res_flowid",  64'(dut_if.ov_flowid), 64'(e.flowid));
          chk("res_dmac",    64'(dut_if.ov_dmac),   64'(e.dmac));
          chk("res_bufid",   64'(dut_if.ov_bufid),  64'(e.bufid));
          chk("res_latency", 64'(cyc),              64'(e.cyc));
        end
      end else begin
        if (dut_if.o_hit !== 1'b0) begin
          chk("hit_outside_strobe", 64'(dut_if.o_hit), 64'd0);
        end
        if (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
          e = exp_q.pop_front();
          chk("missing_result", 64'(dut_if.o_lookup_wr), 64'd1);
        end
      end
    end
  end

  key_t k1, k2, k1x;
  int   t;

  initial begin
    errors = 0;
    checks = 0;
    k1  = make_key(8'd6,  32'hC0A8_0001, 32'hC0A8_0002, 16'd1234, 16'd80);
    k2  = make_key(8'd17, 32'h0A00_0001, 32'h0A00_0063, 16'd5000, 16'd319);
    k1x = k1;
    k1x[103] = ~k1x[103];

    rst = 1'b1;
    dut_if.iv_5tuple_data    = '0;
    dut_if.i_5tuple_data_wr  = 1'b0;
    dut_if.iv_dmac           = '0;
    dut_if.iv_bufid          = '0;
    dut_if.i_tcp_or_udp_flag = 1'b0;
    dut_if.i_cfg_wr          = 1'b0;
    dut_if.iv_cfg_addr       = '0;
    dut_if.iv_cfg_key        = '0;
    dut_if.iv_cfg_flowid     = '0;
    dut_if.i_cfg_valid       = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check_idle_outputs("reset");

    // Single hit at entry 3
    cfg_write(3, k1, 14'h123, 1'b1);
    send_key(k1, 48'h0011_2233_4455, 9'h005, 1'b1, t);
    push_exp(1'b1, 14'h123, 48'h0011_2233_4455, 9'h005, t + 9);
    repeat (12) tick();
    chk("hold_flowid",    64'(dut_if.ov_flowid),   64'h123);
    chk("hold_bufid",     64'(dut_if.ov_bufid),    64'h005);
    chk("hold_hit_low",   64'(dut_if.o_hit),       64'd0);
    chk("hold_wr_low",    64'(dut_if.o_lookup_wr), 64'd0);

    // Duplicates at 2, 3, 6: lowest index wins
    cfg_write(2, k1, 14'h0AA, 1'b1);
    cfg_write(6, k1, 14'h0BB, 1'b1);
    send_key(k1, 48'hA0A0_B0B0_C0C0, 9'h011, 1'b1, t);
    push_exp(1'b1, 14'h0AA, 48'hA0A0_B0B0_C0C0, 9'h011, t + 9);
    repeat (12) tick();

    // Non-TCP/UDP key never hits
    send_key(k1, 48'h1111_1111_1111, 9'h1FF, 1'b0, t);
    push_exp(1'b0, 14'h000, 48'h1111_1111_1111, 9'h1FF, t + 9);
    repeat (12) tick();

    // Key differing only in the top proto bit misses
    send_key(k1x, 48'h2222_2222_2222, 9'h100, 1'b1, t);
    push_exp(1'b0, 14'h000, 48'h2222_2222_2222, 9'h100, t + 9);
    repeat (12) tick();

    // Keys during SEARCH (T+4) and OUTPUT (T+9) are dropped
    send_key(k1, 48'h3333_3333_3333, 9'h033, 1'b1, t);
    push_exp(1'b1, 14'h0AA, 48'h3333_3333_3333, 9'h033, t + 9);
    repeat (3) tick();
    send_key(k2, 48'hDEAD_BEEF_0001, 9'h0DD, 1'b1, t);
    repeat (4) tick();
    send_key(k2, 48'hDEAD_BEEF_0002, 9'h0EE, 1'b1, t);
    tick();
    chk("drop_cnt", 64'(dut_if.ov_drop_cnt), 64'd2);
    repeat (10) tick();

    // Entry 3 invalidated at T+2, before its compare: miss
    cfg_write(2, k1, 14'h0AA, 1'b0);
    cfg_write(6, k1, 14'h0BB, 1'b0);
    send_key(k1, 48'h4444_4444_4444, 9'h044, 1'b1, t);
    push_exp(1'b0, 14'h000, 48'h4444_4444_4444, 9'h044, t + 9);
    tick();
    cfg_write(3, k1, 14'h123, 1'b0);
    repeat (12) tick();

    // Entry 3 invalidated at T+5, after its compare: hit
    cfg_write(3, k1, 14'h123, 1'b1);
    send_key(k1, 48'h5555_5555_5555, 9'h055, 1'b1, t);
    push_exp(1'b1, 14'h123, 48'h5555_5555_5555, 9'h055, t + 9);
    repeat (4) tick();
    cfg_write(3, k1, 14'h123, 1'b0);
    repeat (12) tick();

    // Reset at T+5 aborts the lookup and overrides a simultaneous config write
    cfg_write(3, k1, 14'h123, 1'b1);
    send_key(k1, 48'h6666_6666_6666, 9'h066, 1'b1, t);
    repeat (4) tick();
    rst = 1'b1;
    dut_if.iv_cfg_addr   = 3'd0;
    dut_if.iv_cfg_key    = k1;
    dut_if.iv_cfg_flowid = 14'h0CC;
    dut_if.i_cfg_valid   = 1'b1;
    dut_if.i_cfg_wr      = 1'b1;
    tick();
    rst = 1'b0;
    dut_if.i_cfg_wr = 1'b0;
    check_idle_outputs("mid_reset");
    repeat (8) tick();
    send_key(k1, 48'h7777_7777_7777, 9'h077, 1'b1, t);
    push_exp(1'b0, 14'h000, 48'h7777_7777_7777, 9'h077, t + 9);

    for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
      tick();
    end
    repeat (2) tick();
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/map_flow_lookup.md
MAP_FLOW_LOOKUP -- requirements
Module: map_flow_lookup

Interface
REQ-001 SHALL have parameter ENTRY_NUM, default 8, number of mapping table entries (power of two, 2..16).
REQ-002 SHALL have ports:
- i_clk  in  1  sole clock; all logic on rising edge.
- i_rst  in  1  synchronous, active-high reset.
- iv_5tuple_data  in  104  key {proto[103:96], sip[95:64], dip[63:32], sport[31:16], dport[15:0]}.
- i_5tuple_data_wr  in  1  single-cycle key valid strobe.
- iv_dmac  in  48  destination MAC, valid with the strobe.
- iv_bufid  in  9  packet buffer id, valid with the strobe.
- i_tcp_or_udp_flag  in  1  key holds TCP/UDP fields, valid with the strobe.
- i_cfg_wr  in  1  table write strobe.
- iv_cfg_addr  in  log2(ENTRY_NUM)  entry index.
- iv_cfg_key  in  104  entry key.
- iv_cfg_flowid  in  14  entry TSN flow id.
- i_cfg_valid  in  1  entry valid bit.
- ov_flowid  out  14  matched flow id; 0 on miss.
- o_hit  out  1  lookup matched.
- ov_dmac  out  48  dmac carried through.
- ov_bufid  out  9  bufid carried through.
- o_lookup_wr  out  1  single-cycle result strobe.
- ov_drop_cnt  out  16  keys discarded while busy.

Function
REQ-003 SHALL hold ENTRY_NUM registered entries {valid, key[103:0], flowid[13:0]}.
REQ-004 SHALL write iv_cfg_key, iv_cfg_flowid, i_cfg_valid into entry iv_cfg_addr on the cycle after i_cfg_wr, in any state.
REQ-005 SHALL implement states IDLE, SEARCH, OUTPUT.
REQ-006 IDLE: on i_5tuple_data_wr, SHALL latch key, dmac, bufid and flag, clear the hit register, zero the index counter, and go to SEARCH.
REQ-007 SEARCH: SHALL compare one entry per cycle, index 0 upward; an entry matches when valid=1, latched flag=1, and key equals latched key on all 104 bits.
REQ-008 SEARCH SHALL always visit all ENTRY_NUM entries; the lowest-index match wins, and later matches SHALL NOT overwrite it.
REQ-009 After the index ENTRY_NUM-1 compare, SHALL go to OUTPUT.
REQ-010 OUTPUT: SHALL assert o_lookup_wr for exactly one cycle with o_hit, ov_flowid, ov_dmac and ov_bufid valid, then return to IDLE.
REQ-011 Latency: with the key strobe in cycle T, o_lookup_wr SHALL be high in cycle T+ENTRY_NUM+1 (T+9 at default), regardless of hit, miss or flag.
REQ-012 If latched flag=0, SHALL report o_hit=0 and ov_flowid=0 at the same fixed latency.
REQ-013 Outside the OUTPUT cycle, SHALL drive o_lookup_wr=0 and o_hit=0; ov_flowid, ov_dmac and ov_bufid hold their last values.
REQ-014 A key strobe in SEARCH or OUTPUT SHALL be discarded without disturbing the lookup in progress, and SHALL increment ov_drop_cnt, saturating at 16'hFFFF.
REQ-015 A config write to entry k SHALL be seen by a compare of k in any later cycle; a compare of k in the same cycle as the write uses the old contents.
REQ-016 Duplicate valid keys SHALL be legal; the lowest index wins.

Reset
REQ-017 When i_rst=1 at a clock edge, SHALL clear all entry valid bits, keys and flowids, and set every output to 0.
REQ-018 Reset SHALL also clear internal latches and the index counter, put the state machine in IDLE, and abort any lookup in progress with no o_lookup_wr.
REQ-019 Reset SHALL take priority over i_cfg_wr and i_5tuple_data_wr in the same cycle.

Structure
REQ-020 SHALL take from the shared package: the key width (104), flowid width (14), bufid width (9), state encodings, and the key field bit-offset constants.
REQ-021 SHALL place the table storage and config write port in one sub-module, map_flow_table, with an indexed read port; the FSM and compare logic stay in map_flow_lookup.

Verification
REQ-022 Bench SHALL cover each scenario below:
- Entry 3 = {valid, key K1, flowid 0x123}; strobe K1, flag=1, bufid 0x05 at T -> o_lookup_wr at T+9, o_hit=1, ov_flowid=0x123, ov_bufid=0x05.
- Entries 2 and 6 both hold K1 (flowids 0x0AA, 0x0BB) -> ov_flowid=0x0AA.
- Strobe K1 with flag=0 -> o_hit=0, ov_flowid=0, strobe at T+9.
- Second strobe at T+4 -> ov_drop_cnt=1; single result at T+9 for the first key only.
- Config write invalidates entry 3 at T+2 -> miss. Config write at T+5 targeting entry 3 -> still hit.
- i_rst at T+5 mid-search -> no o_lookup_wr; all outputs 0; table empty; next strobe of K1 misses.
